// File: rtl/ksa4_check_pkg.sv
// Shared types and the golden adder model for the KSA4 result checker.
package ksa4_check_pkg;

  localparam int KSA_W = 4;
  localparam int RES_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Golden {cout,sum} for the 4-bit adder under test.
  function automatic logic [RES_W-1:0] ksa4_expect(input logic [KSA_W-1:0] a,
                                                   input logic [KSA_W-1:0] b,
                                                   input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{KSA_W{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/ksa4_expect_delay.sv
// DEPTH-deep delay line of tagged expected results, aligned to the adder pipeline.
module ksa4_expect_delay
  import ksa4_check_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [RES_W-1:0] in_res,
  output logic             tail_vld,
  output logic [RES_W-1:0] tail_res
);

  logic [DEPTH-1:0]            vld_pipe_q, vld_pipe_d;
  logic [DEPTH-1:0][RES_W-1:0] res_pipe_q, res_pipe_d;

  // Next line contents: clear wins, otherwise shift one stage when enabled.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    res_pipe_d = res_pipe_q;
    if (clr) begin
      vld_pipe_d = '0;
      res_pipe_d = '0;
    end else if (shift_en) begin
      vld_pipe_d[0] = in_vld;
      res_pipe_d[0] = in_res;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        res_pipe_d[i] = res_pipe_q[i-1];
      end
    end
  end

  // Line registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      res_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      res_pipe_q <= res_pipe_d;
    end
  end

  assign tail_vld = vld_pipe_q[DEPTH-1];
  assign tail_res = res_pipe_q[DEPTH-1];

endmodule

// File: rtl/ksa4_result_checker.sv
// Capture-and-check stage behind the KSA4 adder: compares delayed golden
// results against the adder outputs and keeps pass/fail/first-error state.
module ksa4_result_checker
  import ksa4_check_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic             GCLK_Pad,
  input  logic             rst_Pad,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             cin,
  input  logic [3:0]       sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_valid,
  output logic [CNT_W-1:0] err_index,
  output logic [4:0]       err_expected,
  output logic [4:0]       err_observed
);

  localparam logic [3:0] DRAIN_LAST = 4'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [3:0]         drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0]   tail_idx_q, tail_idx_d;
  logic               err_valid_q, err_valid_d;
  logic [CNT_W-1:0]   err_index_q, err_index_d;
  logic [RES_W-1:0]   err_exp_q, err_exp_d;
  logic [RES_W-1:0]   err_obs_q, err_obs_d;

  logic               active, start_go, push, tail_vld;
  logic [RES_W-1:0]   tail_res, obs;

  assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign start_go = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign push     = in_valid && (state_q == ST_RUN);
  assign obs      = {cout, sum};

  ksa4_expect_delay #(.DEPTH(LATENCY)) u_delay (
    .clk      (GCLK_Pad),
    .rst      (rst_Pad),
    .shift_en (active),
    .clr      (start_go),
    .in_vld   (push),
    .in_res   (ksa4_expect(a, b, cin)),
    .tail_vld (tail_vld),
    .tail_res (tail_res)
  );

  // Run control; DRAIN lasts exactly LATENCY edges so the last vector lands on the final one.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
      ST_RUN: if (stop) begin
        state_d     = ST_DRAIN;
        drain_cnt_d = '0;
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = ST_DONE;
        else drain_cnt_d = drain_cnt_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tail compare, saturating counters and first-error capture. The tail index
  // tracks which vector sits at the tail since vectors leave in issue order.
  always_comb begin
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    tail_idx_d  = tail_idx_q;
    err_valid_d = err_valid_q;
    err_index_d = err_index_q;
    err_exp_d   = err_exp_q;
    err_obs_d   = err_obs_q;
    if (start_go) begin
      pass_cnt_d  = '0;
      fail_cnt_d  = '0;
      tail_idx_d  = '0;
      err_valid_d = 1'b0;
      err_index_d = '0;
      err_exp_d   = '0;
      err_obs_d   = '0;
    end else if (active) begin
      if (tail_vld) begin
        tail_idx_d = tail_idx_q + CNT_W'(1);
        if (tail_res == obs) begin
          if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end else begin
          if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
          if (!err_valid_q) begin
            err_valid_d = 1'b1;
            err_index_d = tail_idx_q;
            err_exp_d   = tail_res;
            err_obs_d   = obs;
          end
        end
      end else if (obs != '0) begin
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
        if (!err_valid_q) begin
          err_valid_d = 1'b1;
          err_index_d = '1;
          err_exp_d   = '0;
          err_obs_d   = obs;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge GCLK_Pad) begin
    if (rst_Pad) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      tail_idx_q  <= '0;
      err_valid_q <= 1'b0;
      err_index_q <= '0;
      err_exp_q   <= '0;
      err_obs_q   <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      tail_idx_q  <= tail_idx_d;
      err_valid_q <= err_valid_d;
      err_index_q <= err_index_d;
      err_exp_q   <= err_exp_d;
      err_obs_q   <= err_obs_d;
    end
  end

  assign busy         = active;
  assign done         = (state_q == ST_DONE);
  assign pass_cnt     = pass_cnt_q;
  assign fail_cnt     = fail_cnt_q;
  assign err_valid    = err_valid_q;
  assign err_index    = err_index_q;
  assign err_expected = err_exp_q;
  assign err_observed = err_obs_q;

endmodule
